multiport_reg_file: RTL
=======================

MULTIPORT_REG_FILE -- requirements
Module: multiport_reg_file

Interface
REQ-001 Parameters SHALL be, one per line (name, default, meaning):
- REGFILE_DEPTH, 4, number of entries (>=2).
- REGFILE_WIDTH, 32, bits per entry.
- N_WR, 2, write ports (>=1).
- N_RD, 2, read ports (>=1).
- REGFILE_NSEL, $clog2(REGFILE_DEPTH), select width (derived; not overridden).

REQ-002 Ports SHALL be, one per line (name, direction, width, meaning):
- clk_i, in, 1, single clock.
- rst_ni, in, 1, asynchronous active-low reset.
- ce_i, in, 1, block enable; gates writes and read-register updates.
- flush_i, in, 1, synchronous clear of all entries.
- we_i, in, N_WR, per-port write enable.
- wsel_i, in, N_WR x REGFILE_NSEL, per-port write address.
- wdata_i, in, N_WR x REGFILE_WIDTH, per-port write data.
- re_i, in, N_RD, per-port read enable.
- rsel_i, in, N_RD x REGFILE_NSEL, per-port read address.
- rdata_o, out, N_RD x REGFILE_WIDTH, registered read data.
- rvalid_o, out, N_RD, registered valid bit of the entry read.
- valid_o, out, REGFILE_DEPTH, per-entry written-since-clear flags.
- wr_conflict_o, out, 1, registered one-cycle pulse on a same-address write collision.

REQ-003 Clock and reset SHALL be exactly as stated: one clock clk_i; reset rst_ni asynchronous, active-low.

Function
REQ-004 A write on port k SHALL commit at the rising edge when ce_i=1, we_i[k]=1, flush_i=0 and wsel_i[k] < REGFILE_DEPTH; data wdata_i[k] stored, valid bit of that entry set to 1.
REQ-005 Writes with wsel_i[k] >= REGFILE_DEPTH SHALL be ignored (no state change, no conflict).
REQ-006 If two or more enabled ports target the same in-range address in one cycle, the lowest-index port SHALL win; the others are dropped.
REQ-007 On such a collision, wr_conflict_o SHALL be 1 in the following cycle only; it is 0 in every other cycle, including any cycle with ce_i=0 or flush_i=1 at the preceding edge.
REQ-008 Writes to distinct addresses on different ports in one cycle SHALL all commit.
REQ-009 Read latency SHALL be 1 cycle: when ce_i=1 and re_i[r]=1 at an edge, rdata_o[r]/rvalid_o[r] update to the entry at rsel_i[r].
REQ-010 Reads SHALL be write-first: if a write committing at the same edge targets rsel_i[r], rdata_o[r] takes the winning write data and rvalid_o[r]=1.
REQ-011 When re_i[r]=0 or ce_i=0, rdata_o[r] and rvalid_o[r] SHALL hold their previous values.
REQ-012 A read with rsel_i[r] >= REGFILE_DEPTH SHALL return rdata_o[r]=0, rvalid_o[r]=0.
REQ-013 A read of an entry never written since reset/flush SHALL return 0 data and rvalid_o[r]=0.
REQ-014 flush_i=1 at an edge SHALL, regardless of ce_i, clear all data and valid bits to 0 and clear rdata_o/rvalid_o to 0; writes and reads in that cycle are dropped.
REQ-015 valid_o SHALL reflect the current stored valid bits combinationally from state, with no input-to-output path.
REQ-016 ce_i=0 SHALL freeze all state except under flush_i or reset.
REQ-017 No combinational path SHALL exist from any input to rdata_o, rvalid_o or wr_conflict_o.

Reset
REQ-018 While rst_ni=0, all entries, valid_o, rdata_o, rvalid_o and wr_conflict_o SHALL be 0 immediately, independent of clk_i.
REQ-019 Reset asserted mid-operation SHALL discard any write or read in progress; the first edge after release behaves as a normal cycle.

Verification (defaults DEPTH=4, WIDTH=32, N_WR=2, N_RD=2)
REQ-020 Write port0 addr1=0xDEADBEEF, next cycle read port0 addr1 -> rdata_o[0]=0xDEADBEEF, rvalid_o[0]=1 one cycle later; valid_o=4'b0010.
REQ-021 Same cycle: port0 writes addr2=0x11, port1 writes addr2=0x22, read port1 addr2 -> rdata_o[1]=0x11, rvalid_o[1]=1, wr_conflict_o=1 for exactly one cycle.
REQ-022 Fill all 4 entries, flush_i=1 with simultaneous write to addr0=0x5 and ce_i=0 -> valid_o=0, rdata_o=0, addr0 reads 0 with rvalid_o=0.
REQ-023 ce_i=0 with we_i=2'b11, re_i=2'b11 -> no entry changes, rdata_o/rvalid_o hold prior values, wr_conflict_o=0.
REQ-024 Drop rst_ni asynchronously between edges after writes -> all outputs 0 before next edge; after release, read of addr1 returns 0, rvalid_o=0.

Source files
------------

// File: rtl/multiport_reg_file.sv
// Multi-port register file with per-entry valid flags, lowest-port-wins write
// arbitration, write-first registered reads and a registered collision pulse.
module multiport_reg_file #(
  parameter int REGFILE_DEPTH = 4,
  parameter int REGFILE_WIDTH = 32,
  parameter int N_WR          = 2,
  parameter int N_RD          = 2,
  parameter int REGFILE_NSEL  = $clog2(REGFILE_DEPTH)
) (
  input  logic                                    clk_i,
  input  logic                                    rst_ni,
  input  logic                                    ce_i,
  input  logic                                    flush_i,
  input  logic [N_WR-1:0]                         we_i,
  input  logic [N_WR-1:0][REGFILE_NSEL-1:0]       wsel_i,
  input  logic [N_WR-1:0][REGFILE_WIDTH-1:0]      wdata_i,
  input  logic [N_RD-1:0]                         re_i,
  input  logic [N_RD-1:0][REGFILE_NSEL-1:0]       rsel_i,
  output logic [N_RD-1:0][REGFILE_WIDTH-1:0]      rdata_o,
  output logic [N_RD-1:0]                         rvalid_o,
  output logic [REGFILE_DEPTH-1:0]                valid_o,
  output logic                                    wr_conflict_o
);

  localparam logic [REGFILE_NSEL:0] LP_DEPTH = (REGFILE_NSEL+1)'(REGFILE_DEPTH);

  logic [REGFILE_DEPTH-1:0][REGFILE_WIDTH-1:0] r_mem;
  logic [REGFILE_DEPTH-1:0]                    r_valid;
  logic [N_RD-1:0][REGFILE_WIDTH-1:0]          r_rdata;
  logic [N_RD-1:0]                             r_rvalid;
  logic                                        r_conflict;

  logic [N_WR-1:0]                             w_wr_req;
  logic [N_WR-1:0]                             w_wr_win;
  logic                                        w_conflict;
  logic [REGFILE_DEPTH-1:0]                    w_ent_we;
  logic [REGFILE_DEPTH-1:0][REGFILE_WIDTH-1:0] w_ent_data;
  logic [N_RD-1:0][REGFILE_WIDTH-1:0]          w_rd_data;
  logic [N_RD-1:0]                             w_rd_valid;

  function automatic logic in_range(input logic [REGFILE_NSEL-1:0] sel);
    return ({1'b0, sel} < LP_DEPTH);
  endfunction

  // Write arbitration: a port loses if any lower-index live request hits the same address
  always_comb begin
    w_wr_req = {N_WR{1'b0}};
    for (int k = 0; k < N_WR; k++) begin
      w_wr_req[k] = ce_i & we_i[k] & ~flush_i & in_range(wsel_i[k]);
    end
    w_wr_win = w_wr_req;
    for (int k = 1; k < N_WR; k++) begin
      for (int j = 0; j < k; j++) begin
        w_wr_win[k] = w_wr_win[k] & ~(w_wr_req[j] & (wsel_i[j] == wsel_i[k]));
      end
    end
    w_conflict = |(w_wr_req & ~w_wr_win);
  end

  // Next entry contents; winners are unique per address so merge order is irrelevant
  always_comb begin
    w_ent_we   = {REGFILE_DEPTH{1'b0}};
    w_ent_data = r_mem;
    for (int e = 0; e < REGFILE_DEPTH; e++) begin
      for (int k = 0; k < N_WR; k++) begin
        w_ent_data[e] = (w_wr_win[k] && (wsel_i[k] == REGFILE_NSEL'(e))) ? wdata_i[k] : w_ent_data[e];
        w_ent_we[e]   = w_ent_we[e] | (w_wr_win[k] & (wsel_i[k] == REGFILE_NSEL'(e)));
      end
    end
  end

  // Write-first read lookup; an out-of-range select matches no entry and yields zero
  always_comb begin
    w_rd_data  = {(N_RD*REGFILE_WIDTH){1'b0}};
    w_rd_valid = {N_RD{1'b0}};
    for (int r = 0; r < N_RD; r++) begin
      for (int e = 0; e < REGFILE_DEPTH; e++) begin
        w_rd_data[r]  = (rsel_i[r] == REGFILE_NSEL'(e)) ? w_ent_data[e] : w_rd_data[r];
        w_rd_valid[r] = (rsel_i[r] == REGFILE_NSEL'(e)) ? (r_valid[e] | w_ent_we[e]) : w_rd_valid[r];
      end
    end
  end

  // State update: reset and flush clear everything, ce gates writes and read registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_mem      <= {(REGFILE_DEPTH*REGFILE_WIDTH){1'b0}};
      r_valid    <= {REGFILE_DEPTH{1'b0}};
      r_rdata    <= {(N_RD*REGFILE_WIDTH){1'b0}};
      r_rvalid   <= {N_RD{1'b0}};
      r_conflict <= 1'b0;
    end else if (flush_i) begin
      r_mem      <= {(REGFILE_DEPTH*REGFILE_WIDTH){1'b0}};
      r_valid    <= {REGFILE_DEPTH{1'b0}};
      r_rdata    <= {(N_RD*REGFILE_WIDTH){1'b0}};
      r_rvalid   <= {N_RD{1'b0}};
      r_conflict <= 1'b0;
    end else begin
      r_conflict <= w_conflict;
      if (ce_i) begin
        r_mem   <= w_ent_data;
        r_valid <= r_valid | w_ent_we;
        for (int r = 0; r < N_RD; r++) begin
          if (re_i[r]) begin
            r_rdata[r]  <= w_rd_data[r];
            r_rvalid[r] <= w_rd_valid[r];
          end else begin
            r_rdata[r]  <= r_rdata[r];
            r_rvalid[r] <= r_rvalid[r];
          end
        end
      end else begin
        r_mem   <= r_mem;
        r_valid <= r_valid;
      end
    end
  end

  assign rdata_o       = r_rdata;
  assign rvalid_o      = r_rvalid;
  assign valid_o       = r_valid;
  assign wr_conflict_o = r_conflict;

endmodule
